hazard_ctrl: RTL

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It computes EX-stage forwarding selects and generates stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Sources handled: load-use hazards, taken branches/jumps, and multi-cycle data-memory accesses.
- A small FSM sequences memory-wait stalls and enforces a watchdog timeout.
- Saturating performance counters record stall cycles and branch flushes.

---
 rtl/hazard_ctrl_pkg.sv | 31 +++
 rtl/hazard_ctrl_if.sv | 45 ++++
 rtl/hazard_ctrl_sat_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_W       = 2'b01;
  localparam logic [1:0] FWD_M       = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Memory stage wins over Writeback; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       regwrite_m,
    input logic [4:0] rd_w,
    input logic       regwrite_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = FWD_M;
    else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle; master is the datapath, slave the controller.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic [4:0]       RdM;
  logic             RegWriteM;
  logic             MemReqM;
  logic             MemReadyM;
  logic [4:0]       RdW;
  logic             RegWriteW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_timeout, stall_cycles, flush_events
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (en && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// RV32I hazard controller: EX forwarding, load-use/branch/memory-wait stall and
// flush generation, memory watchdog and saturating performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned       WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              timeout_q;
  logic              timeout_set;
  logic              wait_release;
  logic              mem_stall;
  logic              lw_stall;
  logic              branch_flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_set)
        timeout_q <= 1'b1;
    end
  end

  assign wait_release = (wait_cnt == WAIT_MAX);

  // The counter holds the number of stall cycles already spent in this access,
  // so hitting TIMEOUT means the current cycle is the forced-release cycle.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_set   = 1'b0;
    mem_stall     = 1'b0;
    case (state)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          mem_stall     = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_release) begin
          state_next    = RUN;
          wait_cnt_next = '0;
          timeout_set   = 1'b1;
        end else begin
          mem_stall     = 1'b1;
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  assign lw_stall = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  assign branch_flush = hz.PCSrcE && !mem_stall;

  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (mem_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (lw_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (hz.StallF),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (branch_flush),
    .count (flush_cnt)
  );

  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_events = flush_cnt;

endmodule
